// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: shared-ALU arbiter bus (requesters, ALU drive, response slot, perf counter)
package alu_share_arb_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
  } alu_op_t;
endpackage

interface alu_share_arb_if
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  alu_op_t [NREQ-1:0]    req_op;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  alu_op_t               alu_op;
  logic [31:0]           alu_res;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic [15:0]           perf_ops;
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_res, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_id, perf_ops
  );
  modport master (
    output req_valid, req_a, req_b, req_op, alu_res, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_id, perf_ops
  );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sharing one combinational ALU, one-deep tagged response slot
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic           clk,
  input logic           rst,
  alu_share_arb_if.slave bus
);
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;
  logic           slot_free;
  logic           grant;
  // Scan starts just after the previous winner so every requester gets a turn
  always_comb begin
    winner = last_grant;
    idx    = last_grant;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
  assign slot_free     = !bus.rsp_valid || bus.rsp_ready;
  assign grant         = slot_free && |bus.req_valid;
  assign bus.req_ready = grant ? NREQ'(1) << winner : '0;
  assign bus.alu_a     = grant ? bus.req_a[winner] : '0;
  assign bus.alu_b     = grant ? bus.req_b[winner] : '0;
  assign bus.alu_op    = grant ? bus.req_op[winner] : alu_op_t'(0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
      bus.perf_ops  <= '0;
      last_grant    <= IDW'(NREQ - 1);
    end else if (grant) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= bus.alu_res;
      bus.rsp_id    <= winner;
      bus.perf_ops  <= bus.perf_ops + 16'(bus.perf_ops != 16'hFFFF);
      last_grant    <= winner;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule
